// File: rtl/universal_shift_reg.sv
// Universal shift register with parallel load, shift, rotate
// and an MSB-first serialiser that can be stalled or aborted.
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SER  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Serial output is the register MSB; busy is the SER state flop.
  assign SOUT = Q[WIDTH-1];
  assign BUSY = (state == SER);

  // Register, bit counter, state and done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q     <= '0;
      cnt   <= '0;
      state <= IDLE;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (EN) begin
        unique case (state)
          IDLE: begin
            case (MODE)
              3'b001: Q <= D;
              3'b010: Q <= {Q[WIDTH-2:0], SIN};
              3'b011: Q <= {SIN, Q[WIDTH-1:1]};
              3'b100: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
              3'b101: Q <= {Q[0], Q[WIDTH-1:1]};
              3'b110: begin
                Q     <= D;
                cnt   <= '0;
                state <= SER;
              end
              3'b111: Q <= '0;
              default: ;
            endcase
          end
          SER: begin
            if (MODE == 3'b111) begin
              Q     <= '0;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              Q <= {Q[WIDTH-2:0], 1'b0};
              if (cnt == LAST) begin
                cnt   <= '0;
                state <= IDLE;
                DONE  <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (WIDTH=8):
// stimulus queues expectations, a monitor pops and compares.
module tb_universal_shift_reg;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [2:0] MODE = 3'b000;
  logic [7:0] D = 8'h00;
  logic       SIN = 1'b0;
  logic [7:0] Q;
  logic       SOUT;
  logic       BUSY;
  logic       DONE;

  universal_shift_reg #(.WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .MODE(MODE),
    .D   (D),
    .SIN (SIN),
    .Q   (Q),
    .SOUT(SOUT),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sq[$];
  int   errors = 0;
  int   checks = 0;
  event sample_now;

  task automatic push(input string nm, input logic [7:0] q,
                      input logic busy, input logic done);
    exp_t e;
    e.name = nm;
    e.q    = q;
    e.sout = q[7];
    e.busy = busy;
    e.done = done;
    sq.push_back(e);
  endtask

  // One clock step: drive at negedge, expect after the posedge.
  task automatic step(input logic en, input logic [2:0] mode,
                      input logic [7:0] d, input logic sin,
                      input string nm, input logic [7:0] q,
                      input logic busy, input logic done);
    @(negedge CLK);
    EN   = en;
    MODE = mode;
    D    = d;
    SIN  = sin;
    @(posedge CLK);
    #1;
    push(nm, q, busy, done);
  endtask

  // Monitor: compare every pending expectation at sample points.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK or sample_now);
      while (sq.size() > 0) begin
        e = sq.pop_front();
        checks++;
        if (Q !== e.q || SOUT !== e.sout ||
            BUSY !== e.busy || DONE !== e.done) begin
          errors++;
          $display("FAIL %s: got q=%h sout=%b busy=%b done=%b, want q=%h sout=%b busy=%b done=%b",
                   e.name, Q, SOUT, BUSY, DONE,
                   e.q, e.sout, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    #2;
    push("reset", 8'h00, 1'b0, 1'b0);
    ->sample_now;
    @(negedge CLK);
    RST = 1'b0;

    // load, rotate, shift, hold, clear
    step(1, 3'b001, 8'hA5, 0, "load", 8'hA5, 0, 0);
    step(1, 3'b100, 8'h00, 0, "rotl", 8'h4B, 0, 0);
    step(1, 3'b101, 8'h00, 0, "rotr", 8'hA5, 0, 0);
    step(0, 3'b111, 8'h00, 0, "en0", 8'hA5, 0, 0);
    step(1, 3'b000, 8'hFF, 0, "hold", 8'hA5, 0, 0);
    step(1, 3'b010, 8'h00, 0, "shl0", 8'h4A, 0, 0);
    step(1, 3'b011, 8'h00, 1, "shr1", 8'hA5, 0, 0);
    step(1, 3'b111, 8'h00, 0, "clr", 8'h00, 0, 0);

    // shift in
    step(1, 3'b010, 8'h00, 1, "sin1", 8'h01, 0, 0);
    step(1, 3'b010, 8'h00, 1, "sin2", 8'h03, 0, 0);
    step(1, 3'b010, 8'h00, 1, "sin3", 8'h07, 0, 0);
    step(1, 3'b011, 8'h00, 0, "sinr", 8'h03, 0, 0);

    // serialise C3
    step(1, 3'b110, 8'hC3, 0, "ser_b0", 8'hC3, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ser_b1", 8'h86, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ser_b2", 8'h0C, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ser_b3", 8'h18, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ser_b4", 8'h30, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ser_b5", 8'h60, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ser_b6", 8'hC0, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ser_b7", 8'h80, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ser_done", 8'h00, 0, 1);
    step(0, 3'b000, 8'h00, 0, "done_off", 8'h00, 0, 0);

    // stall, ignored modes
    step(1, 3'b110, 8'hC3, 0, "st_b0", 8'hC3, 1, 0);
    step(1, 3'b000, 8'h00, 0, "st_b1", 8'h86, 1, 0);
    step(0, 3'b000, 8'h00, 0, "st_hold1", 8'h86, 1, 0);
    step(0, 3'b111, 8'h00, 0, "st_hold2", 8'h86, 1, 0);
    step(0, 3'b001, 8'hFF, 0, "st_hold3", 8'h86, 1, 0);
    step(1, 3'b110, 8'hFF, 0, "st_norst", 8'h0C, 1, 0);
    step(1, 3'b101, 8'h00, 1, "st_norot", 8'h18, 1, 0);
    step(1, 3'b000, 8'h00, 0, "st_b4", 8'h30, 1, 0);
    step(1, 3'b000, 8'h00, 0, "st_b5", 8'h60, 1, 0);
    step(1, 3'b000, 8'h00, 0, "st_b6", 8'hC0, 1, 0);
    step(1, 3'b000, 8'h00, 0, "st_b7", 8'h80, 1, 0);
    step(1, 3'b000, 8'h00, 0, "st_done", 8'h00, 0, 1);

    // abort at 4th bit
    step(1, 3'b110, 8'hC3, 0, "ab_b0", 8'hC3, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ab_b1", 8'h86, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ab_b2", 8'h0C, 1, 0);
    step(1, 3'b000, 8'h00, 0, "ab_b3", 8'h18, 1, 0);
    step(1, 3'b111, 8'h00, 0, "abort", 8'h00, 0, 0);
    step(1, 3'b000, 8'h00, 0, "ab_nodone", 8'h00, 0, 0);

    // async reset mid-serialise
    step(1, 3'b110, 8'hA5, 0, "rs_b0", 8'hA5, 1, 0);
    step(1, 3'b000, 8'h00, 0, "rs_b1", 8'h4A, 1, 0);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    push("async_rst", 8'h00, 1'b0, 1'b0);
    ->sample_now;
    @(negedge CLK);
    RST = 1'b0;
    step(0, 3'b000, 8'h00, 0, "rs_nodone", 8'h00, 0, 0);
    step(1, 3'b001, 8'h3C, 0, "rs_first", 8'h3C, 0, 0);

    // back-to-back serialise
    step(1, 3'b110, 8'hC3, 0, "bb_b0", 8'hC3, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb_b1", 8'h86, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb_b2", 8'h0C, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb_b3", 8'h18, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb_b4", 8'h30, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb_b5", 8'h60, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb_b6", 8'hC0, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb_b7", 8'h80, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb_done", 8'h00, 0, 1);
    step(1, 3'b110, 8'h81, 0, "bb2_b0", 8'h81, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb2_b1", 8'h02, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb2_b2", 8'h04, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb2_b3", 8'h08, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb2_b4", 8'h10, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb2_b5", 8'h20, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb2_b6", 8'h40, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb2_b7", 8'h80, 1, 0);
    step(0, 3'b000, 8'h00, 0, "bb2_stall", 8'h80, 1, 0);
    step(1, 3'b000, 8'h00, 0, "bb2_done", 8'h00, 0, 1);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sq.size() > 0; i++)
      @(negedge CLK);
    #1;
    if (sq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
